// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main controller.
//   state_t      : 4-bit FSM state encoding (FETCH = 0), exposed on state_o
//   alu_op_t     : coarse ALU request from the sequencer to alu_decoder
//   OP_* / FN_*  : instruction opcode and R-type funct values
//   ALU_*        : ALUControl codes
//   SRCB_* / PCSRC_* : ALUSrcB and PCSrc mux select codes
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps the sequencer's ALU request and the IR funct field to
// the 3-bit ALUControl code.
//   alu_op        in  request: add, sub, or decode from funct
//   funct         in  IR[5:0]
//   alu_control   out ALUControl code
//   funct_illegal out funct is not one of add/sub/and/or/slt (independent of alu_op)
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       funct_illegal
);

    logic [2:0] funct_ctrl;

    always_comb begin
        funct_ctrl    = ALU_ADD;
        funct_illegal = 1'b0;
        case (funct)
            FN_ADD:  funct_ctrl = ALU_ADD;
            FN_SUB:  funct_ctrl = ALU_SUB;
            FN_AND:  funct_ctrl = ALU_AND;
            FN_OR:   funct_ctrl = ALU_OR;
            FN_SLT:  funct_ctrl = ALU_SLT;
            default: funct_illegal = 1'b1;
        endcase
    end

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB:   alu_control = ALU_SUB;
            ALUOP_FUNCT: alu_control = funct_ctrl;
            default:     alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Main sequencer for the multicycle MIPS core. Steps the shared datapath
// through fetch/decode/execute/memory/writeback and drives every mux select
// and write enable.
//   clk, rst        : core clock, synchronous active-high reset
//   en              : 0 stalls the sequencer (state/counter hold, enables 0)
//   mem_ready       : memory finishes the current access this cycle
//   opcode, funct   : IR fields; zero : ALU zero flag for beq
//   IorD .. PCEn    : datapath selects and write enables
//   halted          : sequencer is parked after an illegal instruction
//   state_o         : current state (debug)
//   retired         : completed-instruction count, wraps
//
// Handshake: a wait state (FETCH, MEMRD, MEMWR) completes only in a cycle
// where en and mem_ready are both 1; a cycle with en=0 never advances the
// FSM, never bumps retired and never issues a write, whatever mem_ready is.
module mips_mc_controller
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mem_ready,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             IorD,
    output logic             IRWrite,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUControl,
    output logic [1:0]       PCSrc,
    output logic             PCEn,
    output logic             halted,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] retired
);

    localparam state_t ILLEGAL_NEXT = ILLEGAL_TRAP ? S_HALT : S_FETCH;

    state_t  state_q;
    state_t  state_d;
    logic    retire;
    alu_op_t alu_op;
    logic    funct_illegal;
    logic    ir_write;
    logic    pc_write;
    logic    mem_write;
    logic    reg_write;
    logic    branch;

    alu_decoder u_alu_decoder (
        .alu_op        (alu_op),
        .funct         (funct),
        .alu_control   (ALUControl),
        .funct_illegal (funct_illegal)
    );

    // State register and retired counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            retired <= '0;
        end else if (en) begin
            state_q <= state_d;
            if (retire) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = funct_illegal ? ILLEGAL_NEXT : S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = ILLEGAL_NEXT;
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWR:    if (mem_ready) state_d = S_FETCH;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_ADDIEXEC: state_d = S_ADDIWB;
            S_ADDIWB:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_FETCH;
        endcase
        // Every return to FETCH from another state ends one instruction,
        // including an illegal instruction treated as a NOP.
        retire = (state_d == S_FETCH) && (state_q != S_FETCH);
    end

    // Output decode. While rst is high the datapath sees a neutral word so a
    // half-finished store or register write cannot leak out.
    always_comb begin
        IorD      = 1'b0;
        MemtoReg  = 1'b0;
        RegDst    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_B;
        PCSrc     = PCSRC_ALU;
        alu_op    = ALUOP_ADD;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        branch    = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    ALUSrcB  = SRCB_FOUR;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                S_DECODE:   ALUSrcB = SRCB_IMM_SL2;
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                S_MEMRD:    IorD = 1'b1;
                S_MEMWB: begin
                    MemtoReg  = 1'b1;
                    reg_write = 1'b1;
                end
                S_MEMWR: begin
                    IorD      = 1'b1;
                    mem_write = 1'b1;
                end
                S_EXECUTE: begin
                    ALUSrcA = 1'b1;
                    alu_op  = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    RegDst    = 1'b1;
                    reg_write = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA = 1'b1;
                    alu_op  = ALUOP_SUB;
                    PCSrc   = PCSRC_ALUOUT;
                    branch  = 1'b1;
                end
                S_ADDIEXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                S_ADDIWB:   reg_write = 1'b1;
                S_JUMP: begin
                    PCSrc    = PCSRC_JUMP;
                    pc_write = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Write enables are qualified by en; selects are not.
    assign IRWrite  = ir_write & en;
    assign MemWrite = mem_write & en;
    assign RegWrite = reg_write & en;
    assign PCEn     = en & (pc_write | (branch & zero));
    assign halted   = (state_q == S_HALT);
    assign state_o  = state_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Bench for mips_mc_controller: a trapping instance (t_*) driven by a
// per-cycle vector table and hand sequences, and a NOP-on-illegal instance
// (n_*) checked against an instruction-level reference model.
module tb_mips_mc_controller;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst, en, mem_ready, zero;
    logic [5:0] opcode, funct;

    logic        t_IorD, t_IRWrite, t_MemWrite, t_MemtoReg, t_RegDst, t_RegWrite, t_ALUSrcA, t_PCEn, t_halted;
    logic [1:0]  t_ALUSrcB, t_PCSrc;
    logic [2:0]  t_ALUControl;
    logic [3:0]  t_state;
    logic [31:0] t_retired;
    logic        n_IorD, n_IRWrite, n_MemWrite, n_MemtoReg, n_RegDst, n_RegWrite, n_ALUSrcA, n_PCEn, n_halted;
    logic [1:0]  n_ALUSrcB, n_PCSrc;
    logic [2:0]  n_ALUControl;
    logic [3:0]  n_state;
    logic [31:0] n_retired;

    logic [3:0] t_strb, n_strb;
    logic [7:0] t_sel;
    assign t_strb = {t_IRWrite, t_MemWrite, t_RegWrite, t_PCEn};
    assign n_strb = {n_IRWrite, n_MemWrite, n_RegWrite, n_PCEn};
    assign t_sel  = {t_IorD, t_MemtoReg, t_RegDst, t_ALUSrcA, t_ALUSrcB, t_PCSrc};

    mips_mc_controller #(.CNT_W(32), .ILLEGAL_TRAP(1'b1)) dut (
        .clk(clk), .rst(rst), .en(en), .mem_ready(mem_ready), .opcode(opcode), .funct(funct), .zero(zero),
        .IorD(t_IorD), .IRWrite(t_IRWrite), .MemWrite(t_MemWrite), .MemtoReg(t_MemtoReg), .RegDst(t_RegDst),
        .RegWrite(t_RegWrite), .ALUSrcA(t_ALUSrcA), .ALUSrcB(t_ALUSrcB), .ALUControl(t_ALUControl),
        .PCSrc(t_PCSrc), .PCEn(t_PCEn), .halted(t_halted), .state_o(t_state), .retired(t_retired)
    );

    mips_mc_controller #(.CNT_W(32), .ILLEGAL_TRAP(1'b0)) dut_nop (
        .clk(clk), .rst(rst), .en(en), .mem_ready(mem_ready), .opcode(opcode), .funct(funct), .zero(zero),
        .IorD(n_IorD), .IRWrite(n_IRWrite), .MemWrite(n_MemWrite), .MemtoReg(n_MemtoReg), .RegDst(n_RegDst),
        .RegWrite(n_RegWrite), .ALUSrcA(n_ALUSrcA), .ALUSrcB(n_ALUSrcB), .ALUControl(n_ALUControl),
        .PCSrc(n_PCSrc), .PCEn(n_PCEn), .halted(n_halted), .state_o(n_state), .retired(n_retired)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Scoreboard counters and compare
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic e, input logic mr);
        @(negedge clk);
        opcode = op; funct = fn; zero = z; en = e; mem_ready = mr;
        #1;
    endtask

    // Vector table: one row per clock, {inputs, expected outputs}
    localparam logic [7:0] SL_NONE = 8'b00000000;
    localparam logic [7:0] SL_FETCH = 8'b00000100;
    localparam logic [7:0] SL_DECODE = 8'b00001100;
    localparam logic [7:0] SL_IMM = 8'b00011000;
    localparam logic [7:0] SL_MEM = 8'b10000000;
    localparam logic [7:0] SL_MEMWB = 8'b01000000;
    localparam logic [7:0] SL_EXEC = 8'b00010000;
    localparam logic [7:0] SL_ALUWB = 8'b00100000;
    localparam logic [7:0] SL_BR = 8'b00010001;
    localparam logic [7:0] SL_JUMP = 8'b00000010;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        e;
        logic        mr;
        logic [3:0]  st;
        logic [3:0]  strb;
        logic [7:0]  sel;
        logic [2:0]  alu;
        logic [31:0] ret;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic e,
                           input logic mr, input logic [3:0] st, input logic [3:0] strb,
                           input logic [7:0] sel, input logic [2:0] alu, input logic [31:0] ret);
        vec_t v;
        v.op = op; v.fn = fn; v.z = z; v.e = e; v.mr = mr;
        v.st = st; v.strb = strb; v.sel = sel; v.alu = alu; v.ret = ret;
        vecs.push_back(v);
    endtask

    // Instruction-level reference model for the NOP-on-illegal instance
    logic [31:0] exp_ret;

    task automatic run_instr(input int idx);
        logic [5:0] fn_list [5] = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
        logic [2:0] alu_list [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
        int cls, fw, mw, body, nact, active, cyc, k;
        int c_ir, c_pc, c_rw, c_mw, c_m2r, c_rd, leak;
        logic [5:0] op, fn;
        logic z, e, mr;
        logic [2:0] exp_alu, alu_seen;
        cls = $urandom_range(0, 7);
        fw = $urandom_range(0, 3);
        mw = $urandom_range(0, 3);
        z = 1'($urandom_range(0, 1));
        fn = 6'($urandom_range(0, 63));
        exp_alu = 3'b010;
        k = $urandom_range(0, 4);
        case (cls)
            0: begin op = OP_LW; body = 3 + mw; end
            1: begin op = OP_SW; body = 2 + mw; end
            2: begin op = OP_RTYPE; fn = fn_list[k]; exp_alu = alu_list[k]; body = 2; end
            3: begin op = OP_BEQ; exp_alu = 3'b110; body = 1; end
            4: begin op = OP_ADDI; body = 2; end
            5: begin op = OP_J; body = 1; end
            6: begin
                do op = 6'($urandom_range(0, 63));
                while (op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J});
                body = 0;
            end
            default: begin
                op = OP_RTYPE;
                do fn = 6'($urandom_range(0, 63));
                while (fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT});
                body = 0;
            end
        endcase
        nact = fw + 2 + body;
        active = 0; cyc = 0;
        c_ir = 0; c_pc = 0; c_rw = 0; c_mw = 0; c_m2r = 0; c_rd = 0; leak = 0;
        alu_seen = 3'b010;
        while (active < nact) begin
            e = (cyc > 60) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (!e) mr = 1'($urandom_range(0, 1));
            else if (active <= fw) mr = (active == fw);
            else if (cls <= 1 && active >= fw + 3 && active <= fw + 3 + mw) mr = (active == fw + 3 + mw);
            else mr = 1'($urandom_range(0, 1));
            drive(op, fn, z, e, mr);
            if (e) begin
                c_ir += int'(n_IRWrite);
                c_pc += int'(n_PCEn);
                c_rw += int'(n_RegWrite);
                c_mw += int'(n_MemWrite);
                c_m2r += int'(n_RegWrite & n_MemtoReg);
                c_rd += int'(n_RegWrite & n_RegDst);
                if (active == fw + 2) alu_seen = n_ALUControl;
                active++;
            end else if (n_strb != 4'b0000) begin
                leak++;
            end
            cyc++;
        end
        @(posedge clk); #1;
        exp_ret = exp_ret + 32'd1;
        check($sformatf("r%0d_c%0d_irwrite", idx, cls), c_ir, 1);
        check($sformatf("r%0d_c%0d_pcen", idx, cls), c_pc, 1 + int'(cls == 3 && z) + int'(cls == 5));
        check($sformatf("r%0d_c%0d_regwrite", idx, cls), c_rw, int'(cls == 0 || cls == 2 || cls == 4));
        check($sformatf("r%0d_c%0d_memwrite", idx, cls), c_mw, (cls == 1) ? mw + 1 : 0);
        check($sformatf("r%0d_c%0d_memtoreg", idx, cls), c_m2r, int'(cls == 0));
        check($sformatf("r%0d_c%0d_regdst", idx, cls), c_rd, int'(cls == 2));
        check($sformatf("r%0d_c%0d_stall_leak", idx, cls), leak, 0);
        check($sformatf("r%0d_c%0d_end_state", idx, cls), n_state, S_FETCH);
        check($sformatf("r%0d_c%0d_retired", idx, cls), n_retired, exp_ret);
        if (cls == 2 || cls == 3) check($sformatf("r%0d_c%0d_alu", idx, cls), alu_seen, exp_alu);
    endtask

    initial begin
        // lw
        add_vec(OP_LW, 6'h00, 0, 1, 1, S_FETCH,    4'b1001, SL_FETCH,  3'b010, 0);
        add_vec(OP_LW, 6'h00, 0, 1, 0, S_DECODE,   4'b0000, SL_DECODE, 3'b010, 0);
        add_vec(OP_LW, 6'h00, 0, 1, 0, S_MEMADR,   4'b0000, SL_IMM,    3'b010, 0);
        add_vec(OP_LW, 6'h00, 0, 1, 1, S_MEMRD,    4'b0000, SL_MEM,    3'b010, 0);
        add_vec(OP_LW, 6'h00, 0, 1, 0, S_MEMWB,    4'b0010, SL_MEMWB,  3'b010, 0);
        // R-type slt, one fetch wait
        add_vec(OP_RTYPE, FN_SLT, 0, 1, 0, S_FETCH,   4'b0000, SL_FETCH,  3'b010, 1);
        add_vec(OP_RTYPE, FN_SLT, 0, 1, 1, S_FETCH,   4'b1001, SL_FETCH,  3'b010, 1);
        add_vec(OP_RTYPE, FN_SLT, 0, 1, 0, S_DECODE,  4'b0000, SL_DECODE, 3'b010, 1);
        add_vec(OP_RTYPE, FN_SLT, 0, 1, 0, S_EXECUTE, 4'b0000, SL_EXEC,   3'b111, 1);
        add_vec(OP_RTYPE, FN_SLT, 0, 1, 0, S_ALUWB,   4'b0010, SL_ALUWB,  3'b010, 1);
        // beq taken, then not taken
        add_vec(OP_BEQ, 6'h00, 1, 1, 1, S_FETCH,  4'b1001, SL_FETCH,  3'b010, 2);
        add_vec(OP_BEQ, 6'h00, 1, 1, 0, S_DECODE, 4'b0000, SL_DECODE, 3'b010, 2);
        add_vec(OP_BEQ, 6'h00, 1, 1, 0, S_BRANCH, 4'b0001, SL_BR,     3'b110, 2);
        add_vec(OP_BEQ, 6'h00, 0, 1, 1, S_FETCH,  4'b1001, SL_FETCH,  3'b010, 3);
        add_vec(OP_BEQ, 6'h00, 0, 1, 0, S_DECODE, 4'b0000, SL_DECODE, 3'b010, 3);
        add_vec(OP_BEQ, 6'h00, 0, 1, 0, S_BRANCH, 4'b0000, SL_BR,     3'b110, 3);
        // sw with three memory wait cycles
        add_vec(OP_SW, 6'h00, 0, 1, 1, S_FETCH,  4'b1001, SL_FETCH,  3'b010, 4);
        add_vec(OP_SW, 6'h00, 0, 1, 0, S_DECODE, 4'b0000, SL_DECODE, 3'b010, 4);
        add_vec(OP_SW, 6'h00, 0, 1, 0, S_MEMADR, 4'b0000, SL_IMM,    3'b010, 4);
        add_vec(OP_SW, 6'h00, 0, 1, 0, S_MEMWR,  4'b0100, SL_MEM,    3'b010, 4);
        add_vec(OP_SW, 6'h00, 0, 1, 0, S_MEMWR,  4'b0100, SL_MEM,    3'b010, 4);
        add_vec(OP_SW, 6'h00, 0, 1, 0, S_MEMWR,  4'b0100, SL_MEM,    3'b010, 4);
        add_vec(OP_SW, 6'h00, 0, 1, 1, S_MEMWR,  4'b0100, SL_MEM,    3'b010, 4);
        // addi
        add_vec(OP_ADDI, 6'h00, 0, 1, 1, S_FETCH,    4'b1001, SL_FETCH,  3'b010, 5);
        add_vec(OP_ADDI, 6'h00, 0, 1, 0, S_DECODE,   4'b0000, SL_DECODE, 3'b010, 5);
        add_vec(OP_ADDI, 6'h00, 0, 1, 0, S_ADDIEXEC, 4'b0000, SL_IMM,    3'b010, 5);
        add_vec(OP_ADDI, 6'h00, 0, 1, 0, S_ADDIWB,   4'b0010, SL_NONE,   3'b010, 5);
        // j
        add_vec(OP_J, 6'h00, 0, 1, 1, S_FETCH,  4'b1001, SL_FETCH,  3'b010, 6);
        add_vec(OP_J, 6'h00, 0, 1, 0, S_DECODE, 4'b0000, SL_DECODE, 3'b010, 6);
        add_vec(OP_J, 6'h00, 0, 1, 0, S_JUMP,   4'b0001, SL_JUMP,   3'b010, 6);
        // j again, stalled three cycles in FETCH with mem_ready high
        add_vec(OP_J, 6'h00, 0, 0, 1, S_FETCH,  4'b0000, SL_FETCH,  3'b010, 7);
        add_vec(OP_J, 6'h00, 0, 0, 1, S_FETCH,  4'b0000, SL_FETCH,  3'b010, 7);
        add_vec(OP_J, 6'h00, 0, 0, 1, S_FETCH,  4'b0000, SL_FETCH,  3'b010, 7);
        add_vec(OP_J, 6'h00, 0, 1, 1, S_FETCH,  4'b1001, SL_FETCH,  3'b010, 7);
        add_vec(OP_J, 6'h00, 0, 1, 0, S_DECODE, 4'b0000, SL_DECODE, 3'b010, 7);
        add_vec(OP_J, 6'h00, 0, 1, 0, S_JUMP,   4'b0001, SL_JUMP,   3'b010, 7);

        // Reset: outputs neutral during rst even with en/mem_ready high
        rst = 1'b1; en = 1'b1; mem_ready = 1'b1; opcode = OP_LW; funct = 6'h00; zero = 1'b0;
        @(negedge clk); #1;
        check("rst_strobes", t_strb, 4'b0000);
        check("rst_selects", t_sel, 8'h00);
        check("rst_alu", t_ALUControl, 3'b010);
        check("rst_state", t_state, S_FETCH);
        check("rst_retired", t_retired, 0);
        rst = 1'b0; en = 1'b0; mem_ready = 1'b0;

        // Table
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].op, vecs[i].fn, vecs[i].z, vecs[i].e, vecs[i].mr);
            check($sformatf("v%0d_state", i), t_state, vecs[i].st);
            check($sformatf("v%0d_strobes", i), t_strb, vecs[i].strb);
            check($sformatf("v%0d_selects", i), t_sel, vecs[i].sel);
            check($sformatf("v%0d_alu", i), t_ALUControl, vecs[i].alu);
            check($sformatf("v%0d_retired", i), t_retired, vecs[i].ret);
        end
        @(posedge clk); #1;
        check("table_end_state", t_state, S_FETCH);
        check("table_end_retired", t_retired, 8);

        // sw: stall inside MEMWR, then reset mid-store
        drive(OP_SW, 6'h00, 0, 1, 1);
        drive(OP_SW, 6'h00, 0, 1, 0);
        drive(OP_SW, 6'h00, 0, 1, 0);
        drive(OP_SW, 6'h00, 0, 1, 0);
        check("memwr_state", t_state, S_MEMWR);
        check("memwr_strobe", t_strb, 4'b0100);
        drive(OP_SW, 6'h00, 0, 0, 1);
        check("memwr_stall_strobe", t_strb, 4'b0000);
        drive(OP_SW, 6'h00, 0, 0, 1);
        check("memwr_stall_hold", t_state, S_MEMWR);
        check("memwr_stall_retired", t_retired, 8);
        @(negedge clk); rst = 1'b1; en = 1'b1; mem_ready = 1'b0; #1;
        check("memwr_rst_strobe", t_strb, 4'b0000);
        check("memwr_rst_selects", t_sel, 8'h00);
        @(negedge clk); rst = 1'b0; en = 1'b0; #1;
        check("memwr_rst_state", t_state, S_FETCH);
        check("memwr_rst_retired", t_retired, 0);

        // Illegal opcode: trap instance halts, NOP instance retires it
        drive(6'h3f, 6'h00, 0, 1, 1);
        drive(6'h3f, 6'h00, 0, 1, 0);
        check("ill_decode_state", t_state, S_DECODE);
        for (int k = 0; k < 20; k++) begin
            drive(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1'b1,
                  1'($urandom_range(0, 1)));
            check($sformatf("halt%0d_halted", k), t_halted, 1'b1);
            check($sformatf("halt%0d_strobes", k), t_strb, 4'b0000);
            check($sformatf("halt%0d_state", k), t_state, S_HALT);
            if (k == 0) begin
                check("nop_ill_state", n_state, S_FETCH);
                check("nop_ill_retired", n_retired, 1);
                check("nop_ill_halted", n_halted, 1'b0);
            end
        end
        check("halt_retired", t_retired, 0);
        @(negedge clk); rst = 1'b1; en = 1'b1; mem_ready = 1'b1; #1;
        check("halt_rst_strobes", t_strb, 4'b0000);
        @(negedge clk); rst = 1'b0; en = 1'b0; #1;
        check("halt_rst_state", t_state, S_FETCH);
        check("halt_rst_halted", t_halted, 1'b0);
        check("nop_rst_retired", n_retired, 0);

        // Random instruction stream against the reference model
        exp_ret = 32'd0;
        for (int n = 0; n < 300; n++) begin
            run_instr(n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
